serial_adder: RTL

- Bit-serial two-operand adder: accepts WIDTH-bit operands in parallel, adds them LSB-first at one bit per clock through a single one-bit full-adder cell with a registered carry, and returns the parallel sum, carry-out and signed overflow.
- Sits downstream of the team's one-bit full-adder cell. It consumes that cell's sum/carry pair each cycle, providing area-minimal multi-bit addition for datapaths where latency is acceptable.
- Valid/ready handshakes on input and output.

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/serial_adder_bitcell.sv | 13 +
 rtl/serial_adder.sv | 114 +++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings and default width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_bitcell.sv
// One-bit combinational full adder used as the serial adder's only arithmetic cell.
module serial_add_bitcell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic c
);

  assign s = a ^ b ^ ci;
  assign c = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial two-operand adder, LSB first, one bit per clock, valid/ready on both sides.
// Optional subtraction is enabled with `define SERIAL_ADDER_SUB_EN.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | adding one bit per clock
// DONE  | result presented, out_valid high until out_ready
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh, b_sh;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic               bit_s, bit_c;
  logic               last_bit;
  logic [WIDTH-1:0]   b_ld;
  logic               c_ld;

`ifdef SERIAL_ADDER_SUB_EN
  // a - b = a + ~b + 1
  assign b_ld = sub ? ~b : b;
  assign c_ld = sub ? 1'b1 : cin;
`else
  logic sub_unused;
  assign sub_unused = sub;
  assign b_ld       = b;
  assign c_ld       = cin;
`endif

  serial_add_bitcell u_bitcell (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (bit_s),
    .c  (bit_c)
  );

  assign last_bit  = (state_q == RUN) && (cnt == CNT_W'(WIDTH - 1));
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_bit)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Sum bits are collected in the vacated MSBs of a_sh so the result register
  // only changes at completion and stays stable until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b_ld;
            carry <= c_ld;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh  <= {bit_s, a_sh[WIDTH-1:1]};
          b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
          carry <= bit_c;
          cnt   <= cnt + CNT_W'(1);
          if (last_bit) begin
            sum  <= {bit_s, a_sh[WIDTH-1:1]};
            cout <= bit_c;
            ovf  <= carry ^ bit_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
